mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 125 ++++++++++++
 tb/tb_mem_responder.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port word memory responder: one request in flight, response LATENCY edges after acceptance.
// Request is held by the initiator until mem_resp; no other backpressure. Array contents survive reset.
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [29:0] idx_q;
  logic [31:0] wdata_q;
  logic        wr_q;

  logic        req;
  logic        accept;
  logic        go_resp;
  logic [29:0] cur_idx;
  logic [31:0] cur_wdata;
  logic        cur_wr;
  logic        in_range;
  logic        unused_addr_lsb;

  logic [31:0] mem [DEPTH_WORDS];

  assign req             = mem_read | mem_write;
  assign unused_addr_lsb = ^mem_addr[1:0];

  // In IDLE the live inputs describe the request (needed when LATENCY=1 commits at acceptance).
  assign cur_idx   = (state_q == IDLE) ? mem_addr[31:2] : idx_q;
  assign cur_wdata = (state_q == IDLE) ? mem_wdata      : wdata_q;
  assign cur_wr    = (state_q == IDLE) ? mem_write      : wr_q;
  assign in_range  = (cur_idx < 30'(DEPTH_WORDS));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    accept     = 1'b0;
    go_resp    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (LATENCY <= 1) begin
            state_d = RESP;
            go_resp = 1'b1;
          end else begin
            state_d    = WAIT;
            wait_cnt_d = 4'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (wait_cnt_q == 4'd0) begin
          state_d = RESP;
          go_resp = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
      idx_q      <= 30'd0;
      wdata_q    <= 32'd0;
      wr_q       <= 1'b0;
      mem_resp   <= 1'b0;
      mem_rdata  <= 32'd0;
      mem_err    <= 1'b0;
      rd_count   <= 16'd0;
      wr_count   <= 16'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_resp   <= go_resp;
      if (accept) begin
        idx_q   <= mem_addr[31:2];
        wdata_q <= mem_wdata;
        wr_q    <= mem_write;
        if ((mem_read && mem_write) || !in_range) begin
          mem_err <= 1'b1;
        end
      end
      if (go_resp) begin
        if (cur_wr) begin
          if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end else begin
          if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
          mem_rdata <= in_range ? mem[cur_idx[AW-1:0]] : 32'd0;
        end
      end
    end
  end

  // Storage has no reset; a reset edge suppresses any commit.
  always_ff @(posedge clk) begin
    if (!rst && go_resp && cur_wr && in_range) begin
      mem[cur_idx[AW-1:0]] <= cur_wdata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus randomized traffic against a word-array model.
module tb_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        mem_err;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] model_mem [DEPTH];
  bit          model_vld [DEPTH];
  int          exp_rd;
  int          exp_wr;
  bit          exp_err;
  logic [31:0] exp_rdata;

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp),
    .mem_err   (mem_err),
    .rd_count  (rd_count),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    exp_rd    = 0;
    exp_wr    = 0;
    exp_err   = 1'b0;
    exp_rdata = 32'd0;
  endfunction

  function automatic void model_apply(input bit rd, input bit wr, input logic [31:0] addr,
                                      input logic [31:0] wd);
    int unsigned idx;
    bit oor;
    idx = addr >> 2;
    oor = (idx >= DEPTH);
    if ((rd && wr) || oor) exp_err = 1'b1;
    if (wr) begin
      if (exp_wr < 65535) exp_wr++;
      if (!oor) begin
        model_mem[idx] = wd;
        model_vld[idx] = 1'b1;
      end
    end else begin
      if (exp_rd < 65535) exp_rd++;
      exp_rdata = oor ? 32'd0 : model_mem[idx];
    end
  endfunction

  // Drives one request from IDLE, returns edges-to-response (-1 on timeout), ends back in IDLE.
  task automatic run_req(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output logic [31:0] rdata);
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = addr;
    mem_wdata = wd;
    lat       = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (mem_resp) begin
        lat = i;
        break;
      end
      mem_addr  = $urandom;
      mem_wdata = $urandom;
    end
    rdata     = mem_rdata;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    mem_read  = 1'b1;
    mem_write = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (mem_resp !== 1'b0) begin n_fail++; $display("FAIL reset_resp got %b exp 0", mem_resp); end
    n_checks++;
    if (mem_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", mem_rdata); end
    n_checks++;
    if (mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", mem_err); end
    n_checks++;
    if (rd_count !== 16'd0 || wr_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_counts got rd=%0d wr=%0d exp 0/0", rd_count, wr_count);
    end
    mem_read = 1'b0;
    rst      = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int lat;
    logic [31:0] rd;
    model_apply(0, 1, 32'h40, 32'hCAFEF00D);
    run_req(0, 1, 32'h40, 32'hCAFEF00D, lat, rd);
    n_checks++;
    if (lat !== LAT) begin n_fail++; $display("FAIL wr_latency got %0d exp %0d", lat, LAT); end
    n_checks++;
    if (wr_count !== 16'd1) begin n_fail++; $display("FAIL wr_count got %0d exp 1", wr_count); end
    n_checks++;
    if (mem_err !== 1'b0) begin n_fail++; $display("FAIL wr_err got %b exp 0", mem_err); end
    n_checks++;
    if (mem_resp !== 1'b0) begin n_fail++; $display("FAIL wr_resp_width got %b exp 0", mem_resp); end

    model_apply(1, 0, 32'h43, 32'h0);
    run_req(1, 0, 32'h43, 32'h0, lat, rd);
    n_checks++;
    if (lat !== LAT) begin n_fail++; $display("FAIL rd_latency got %0d exp %0d", lat, LAT); end
    n_checks++;
    if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rd_data got %h exp cafef00d", rd); end
    n_checks++;
    if (rd_count !== 16'd1) begin n_fail++; $display("FAIL rd_count got %0d exp 1", rd_count); end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (mem_rdata !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL rd_hold got %h exp cafef00d", mem_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap;
    logic [31:0] rd;
    model_apply(0, 1, 32'h44, 32'h5A5A1234);
    run_req(0, 1, 32'h44, 32'h5A5A1234, lat, rd);
    model_apply(1, 0, 32'h40, 32'h0);
    model_apply(1, 0, 32'h44, 32'h0);

    mem_read  = 1'b1;
    mem_write = 1'b0;
    mem_addr  = 32'h40;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (mem_resp) begin lat = i; break; end
    end
    rd = mem_rdata;
    n_checks++;
    if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b2b_first_data got %h exp cafef00d", rd); end
    mem_addr = 32'h44;
    gap = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (mem_resp) begin gap = i; break; end
    end
    rd = mem_rdata;
    mem_read = 1'b0;
    n_checks++;
    if (lat !== LAT) begin n_fail++; $display("FAIL b2b_first_latency got %0d exp %0d", lat, LAT); end
    n_checks++;
    if (gap !== LAT + 1) begin n_fail++; $display("FAIL b2b_gap got %0d exp %0d", gap, LAT + 1); end
    n_checks++;
    if (rd !== 32'h5A5A1234) begin n_fail++; $display("FAIL b2b_second_data got %h exp 5a5a1234", rd); end
    @(posedge clk); #1;
    n_checks++;
    if (mem_resp !== 1'b0) begin n_fail++; $display("FAIL b2b_dup_resp got %b exp 0", mem_resp); end
    n_checks++;
    if (rd_count !== 16'(exp_rd)) begin n_fail++; $display("FAIL b2b_rd_count got %0d exp %0d", rd_count, exp_rd); end
  endtask

  task automatic test_out_of_range();
    int lat;
    logic [31:0] rd;
    model_apply(1, 0, 32'h00001000, 32'h0);
    run_req(1, 0, 32'h00001000, 32'h0, lat, rd);
    n_checks++;
    if (lat !== LAT) begin n_fail++; $display("FAIL oor_latency got %0d exp %0d", lat, LAT); end
    n_checks++;
    if (rd !== 32'd0) begin n_fail++; $display("FAIL oor_rdata got %h exp 0", rd); end
    n_checks++;
    if (mem_err !== 1'b1) begin n_fail++; $display("FAIL oor_err got %b exp 1", mem_err); end
    n_checks++;
    if (rd_count !== 16'(exp_rd)) begin n_fail++; $display("FAIL oor_rd_count got %0d exp %0d", rd_count, exp_rd); end

    model_apply(0, 1, 32'h00001040, 32'hDEADBEEF);
    run_req(0, 1, 32'h00001040, 32'hDEADBEEF, lat, rd);
    n_checks++;
    if (wr_count !== 16'(exp_wr)) begin n_fail++; $display("FAIL oor_wr_count got %0d exp %0d", wr_count, exp_wr); end
    model_apply(1, 0, 32'h40, 32'h0);
    run_req(1, 0, 32'h40, 32'h0, lat, rd);
    n_checks++;
    if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL oor_write_dropped got %h exp cafef00d", rd); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (mem_err !== 1'b1) begin n_fail++; $display("FAIL oor_err_sticky got %b exp 1", mem_err); end
    do_reset();
    n_checks++;
    if (mem_err !== 1'b0) begin n_fail++; $display("FAIL oor_err_cleared got %b exp 0", mem_err); end
  endtask

  task automatic test_both_high();
    int lat;
    logic [31:0] rd;
    model_apply(1, 1, 32'h8, 32'h12345678);
    run_req(1, 1, 32'h8, 32'h12345678, lat, rd);
    n_checks++;
    if (wr_count !== 16'd1 || rd_count !== 16'd0) begin
      n_fail++; $display("FAIL both_counts got rd=%0d wr=%0d exp 0/1", rd_count, wr_count);
    end
    n_checks++;
    if (mem_err !== 1'b1) begin n_fail++; $display("FAIL both_err got %b exp 1", mem_err); end
    n_checks++;
    if (rd !== 32'd0) begin n_fail++; $display("FAIL both_rdata_unchanged got %h exp 0", rd); end
    model_apply(1, 0, 32'h8, 32'h0);
    run_req(1, 0, 32'h8, 32'h0, lat, rd);
    n_checks++;
    if (rd !== 32'h12345678) begin n_fail++; $display("FAIL both_readback got %h exp 12345678", rd); end
  endtask

  task automatic test_abort();
    int lat;
    bit saw;
    logic [31:0] rd;
    model_apply(0, 1, 32'h14, 32'h11112222);
    run_req(0, 1, 32'h14, 32'h11112222, lat, rd);
    mem_write = 1'b1;
    mem_addr  = 32'h14;
    mem_wdata = 32'h33334444;
    @(posedge clk); #1;
    mem_write = 1'b0;
    saw = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (mem_resp) saw = 1'b1;
    end
    n_checks++;
    if (saw !== 1'b0) begin n_fail++; $display("FAIL abort_resp got %b exp 0", saw); end
    n_checks++;
    if (wr_count !== 16'(exp_wr)) begin n_fail++; $display("FAIL abort_wr_count got %0d exp %0d", wr_count, exp_wr); end
    model_apply(1, 0, 32'h14, 32'h0);
    run_req(1, 0, 32'h14, 32'h0, lat, rd);
    n_checks++;
    if (rd !== 32'h11112222) begin n_fail++; $display("FAIL abort_no_commit got %h exp 11112222", rd); end
  endtask

  task automatic test_reset_abort();
    int lat;
    bit saw;
    logic [31:0] rd;
    model_apply(0, 1, 32'h10, 32'h0BADF00D);
    run_req(0, 1, 32'h10, 32'h0BADF00D, lat, rd);
    do_reset();
    mem_write = 1'b1;
    mem_addr  = 32'h10;
    mem_wdata = 32'hAAAA5555;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    mem_write = 1'b0;
    rst       = 1'b0;
    model_reset();
    saw = mem_resp;
    repeat (4) begin
      @(posedge clk); #1;
      if (mem_resp) saw = 1'b1;
    end
    n_checks++;
    if (saw !== 1'b0) begin n_fail++; $display("FAIL rstabort_resp got %b exp 0", saw); end
    n_checks++;
    if (rd_count !== 16'd0 || wr_count !== 16'd0) begin
      n_fail++; $display("FAIL rstabort_counts got rd=%0d wr=%0d exp 0/0", rd_count, wr_count);
    end
    model_apply(1, 0, 32'h10, 32'h0);
    run_req(1, 0, 32'h10, 32'h0, lat, rd);
    n_checks++;
    if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL rstabort_no_commit got %h exp 0badf00d", rd); end
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] rd;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      int unsigned idx;
      int unsigned kind;
      bit r, w;
      logic [31:0] addr, wd;
      kind = $urandom_range(0, 99);
      idx  = (kind < 10) ? DEPTH + $urandom_range(0, 4000) : $urandom_range(0, 63);
      r    = $urandom_range(0, 1);
      w    = !r;
      if (kind >= 10 && kind < 18) begin r = 1'b1; w = 1'b1; end
      if (r && !w && idx < DEPTH && !model_vld[idx]) begin r = 1'b0; w = 1'b1; end
      addr = (32'(idx) << 2) | 32'($urandom_range(0, 3));
      wd   = $urandom;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      model_apply(r, w, addr, wd);
      run_req(r, w, addr, wd, lat, rd);
      n_checks++;
      if (lat !== LAT) begin n_fail++; $display("FAIL rand_latency op=%0d got %0d exp %0d", n, lat, LAT); end
      n_checks++;
      if (rd !== exp_rdata) begin n_fail++; $display("FAIL rand_rdata op=%0d got %h exp %h", n, rd, exp_rdata); end
      n_checks++;
      if (rd_count !== 16'(exp_rd)) begin n_fail++; $display("FAIL rand_rd_count op=%0d got %0d exp %0d", n, rd_count, exp_rd); end
      n_checks++;
      if (wr_count !== 16'(exp_wr)) begin n_fail++; $display("FAIL rand_wr_count op=%0d got %0d exp %0d", n, wr_count, exp_wr); end
      n_checks++;
      if (mem_err !== exp_err) begin n_fail++; $display("FAIL rand_err op=%0d got %b exp %b", n, mem_err, exp_err); end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_vld[i] = 1'b0;
    model_reset();
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    @(posedge clk); #1;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_out_of_range();
    test_both_high();
    test_abort();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
